// File: rtl/idu_stage.sv
// Pipelined decode stage: accepts instr/pc from IFU, reads REGU, builds the immediate and registers one
// output slot for EXU; a per-register pending-writer scoreboard holds back RAW/WAW hazards until WBU retires.

package idu_pkg;
    typedef enum logic [2:0] {
        VALC_ZERO    = 3'd0,
        VALC_R       = 3'd1,
        VALC_I       = 3'd2,
        VALC_I_SHAMT = 3'd3,
        VALC_S       = 3'd4,
        VALC_B       = 3'd5,
        VALC_U       = 3'd6,
        VALC_J       = 3'd7
    } valc_sel_e;
endpackage

module idu_stage
    import idu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_WIDTH = 5,
    parameter int SB_W      = 2,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IFU_i_valid,
    output logic                 IDU_o_ready,
    input  logic [WIDTH-1:0]     IFU_i_instr,
    input  logic [WIDTH-1:0]     IFU_i_pc,
    input  logic [2:0]           CTRL_i_valC_sel,
    input  logic                 CTRL_i_reg_wen,
    input  logic                 CTRL_i_use_rs1,
    input  logic                 CTRL_i_use_rs2,
    output logic [REG_WIDTH-1:0] IDU_o_rs1,
    output logic [REG_WIDTH-1:0] IDU_o_rs2,
    input  logic [WIDTH-1:0]     REGU_i_rdata1,
    input  logic [WIDTH-1:0]     REGU_i_rdata2,
    output logic                 IDU_o_valid,
    input  logic                 EXU_i_ready,
    output logic [WIDTH-1:0]     IDU_o_pc,
    output logic [WIDTH-1:0]     IDU_o_valA,
    output logic [WIDTH-1:0]     IDU_o_valB,
    output logic [WIDTH-1:0]     IDU_o_valC,
    output logic [REG_WIDTH-1:0] IDU_o_rd,
    output logic                 IDU_o_rd_wen,
    input  logic                 WBU_i_retire,
    input  logic [REG_WIDTH-1:0] WBU_i_rd,
    input  logic                 CTRL_i_flush,
    output logic [CNT_W-1:0]     IDU_o_stall_cnt,
    output logic                 IDU_o_sb_err
);

    localparam int NREG = 2 ** REG_WIDTH;
    localparam logic [SB_W-1:0] SB_MAX = '1;

    logic [REG_WIDTH-1:0] in_rs1, in_rs2, in_rd;
    logic                 in_wen;
    logic [WIDTH-1:0]     valc;
    logic                 hazard, fire_in, kill_wr, wb_hit, retire_bad;
    logic [SB_W-1:0]      sb      [NREG];
    logic [SB_W-1:0]      sb_next [NREG];
    logic                 unused_opcode;

    assign in_rs1 = IFU_i_instr[15 +: REG_WIDTH];
    assign in_rs2 = IFU_i_instr[20 +: REG_WIDTH];
    assign in_rd  = IFU_i_instr[7 +: REG_WIDTH];
    assign in_wen = CTRL_i_reg_wen && (in_rd != '0);

    assign IDU_o_rs1     = in_rs1;
    assign IDU_o_rs2     = in_rs2;
    assign unused_opcode = ^IFU_i_instr[6:0];

    always_comb begin
        // NOTE: default first so every path assigns valc and no latch is inferred.
        valc = '0;
        case (valc_sel_e'(CTRL_i_valC_sel))
            VALC_U:       valc = WIDTH'($signed({IFU_i_instr[31:12], 12'b0}));
            VALC_I:       valc = WIDTH'($signed(IFU_i_instr[31:20]));
            VALC_I_SHAMT: valc = WIDTH'(IFU_i_instr[24:20]);
            VALC_S:       valc = WIDTH'($signed({IFU_i_instr[31:25], IFU_i_instr[11:7]}));
            VALC_B:       valc = WIDTH'($signed({IFU_i_instr[31], IFU_i_instr[7],
                                                 IFU_i_instr[30:25], IFU_i_instr[11:8], 1'b0}));
            VALC_J:       valc = WIDTH'($signed({IFU_i_instr[31], IFU_i_instr[19:12],
                                                 IFU_i_instr[20], IFU_i_instr[30:21], 1'b0}));
            default:      valc = '0;
        endcase
    end

    // No bypass: a same-cycle retire of a source still stalls, REGU only updates on that edge.
    assign hazard = (CTRL_i_use_rs1 && (in_rs1 != '0) && (sb[in_rs1] != '0))
                 || (CTRL_i_use_rs2 && (in_rs2 != '0) && (sb[in_rs2] != '0))
                 || (in_wen && (sb[in_rd] == SB_MAX));

    assign IDU_o_ready = (!IDU_o_valid || EXU_i_ready) && !hazard && !CTRL_i_flush;
    assign fire_in     = IFU_i_valid && IDU_o_ready;

    // A writer sitting in the slot that a flush kills will never reach WBU, so it is un-counted here.
    assign kill_wr    = CTRL_i_flush && IDU_o_valid && !EXU_i_ready && IDU_o_rd_wen;
    assign wb_hit     = WBU_i_retire && (WBU_i_rd != '0);
    assign retire_bad = wb_hit && (sb[WBU_i_rd] == '0)
                     && !(fire_in && in_wen && (in_rd == WBU_i_rd));

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            if (r == 0) begin
                sb_next[r] = '0;
            end else begin
                sb_next[r] = sb[r]
                           + SB_W'(fire_in && in_wen && (in_rd == REG_WIDTH'(r)))
                           - SB_W'(wb_hit && (WBU_i_rd == REG_WIDTH'(r)) && (sb[r] != '0))
                           - SB_W'(kill_wr && (IDU_o_rd == REG_WIDTH'(r)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the scoreboard is a small flop array, so it is cleared on reset like any register.
            for (int r = 0; r < NREG; r++) begin
                sb[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                sb[r] <= sb_next[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            IDU_o_valid  <= 1'b0;
            IDU_o_pc     <= '0;
            IDU_o_valA   <= '0;
            IDU_o_valB   <= '0;
            IDU_o_valC   <= '0;
            IDU_o_rd     <= '0;
            IDU_o_rd_wen <= 1'b0;
        end else if (fire_in) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            IDU_o_valid  <= 1'b1;
            IDU_o_pc     <= IFU_i_pc;
            IDU_o_valA   <= REGU_i_rdata1;
            IDU_o_valB   <= REGU_i_rdata2;
            IDU_o_valC   <= valc;
            IDU_o_rd     <= in_rd;
            IDU_o_rd_wen <= in_wen;
        end else if (EXU_i_ready || CTRL_i_flush) begin
            IDU_o_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            IDU_o_stall_cnt <= '0;
            IDU_o_sb_err    <= 1'b0;
        end else begin
            if (IFU_i_valid && !IDU_o_ready) begin
                IDU_o_stall_cnt <= IDU_o_stall_cnt + CNT_W'(1);
            end
            if (retire_bad) begin
                IDU_o_sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_idu_stage.sv
// Directed bench for idu_stage: stimulus pushes expected slots into a queue, a negedge monitor
// pops and compares whenever EXU consumes the slot; control/status outputs are checked inline.

module tb_idu_stage;
    import idu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        IFU_i_valid, IDU_o_ready;
    logic [31:0] IFU_i_instr, IFU_i_pc;
    logic [2:0]  CTRL_i_valC_sel;
    logic        CTRL_i_reg_wen, CTRL_i_use_rs1, CTRL_i_use_rs2;
    logic [4:0]  IDU_o_rs1, IDU_o_rs2;
    logic [31:0] REGU_i_rdata1, REGU_i_rdata2;
    logic        IDU_o_valid, EXU_i_ready;
    logic [31:0] IDU_o_pc, IDU_o_valA, IDU_o_valB, IDU_o_valC;
    logic [4:0]  IDU_o_rd;
    logic        IDU_o_rd_wen;
    logic        WBU_i_retire;
    logic [4:0]  WBU_i_rd;
    logic        CTRL_i_flush;
    logic [31:0] IDU_o_stall_cnt;
    logic        IDU_o_sb_err;

    logic [31:0] rf [32];
    assign REGU_i_rdata1 = rf[IDU_o_rs1];
    assign REGU_i_rdata2 = rf[IDU_o_rs2];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [4:0]  rd;
        logic        wen;
    } slot_t;

    slot_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    idu_stage #(.WIDTH(32), .REG_WIDTH(5), .SB_W(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .IFU_i_valid(IFU_i_valid), .IDU_o_ready(IDU_o_ready),
        .IFU_i_instr(IFU_i_instr), .IFU_i_pc(IFU_i_pc),
        .CTRL_i_valC_sel(CTRL_i_valC_sel), .CTRL_i_reg_wen(CTRL_i_reg_wen),
        .CTRL_i_use_rs1(CTRL_i_use_rs1), .CTRL_i_use_rs2(CTRL_i_use_rs2),
        .IDU_o_rs1(IDU_o_rs1), .IDU_o_rs2(IDU_o_rs2),
        .REGU_i_rdata1(REGU_i_rdata1), .REGU_i_rdata2(REGU_i_rdata2),
        .IDU_o_valid(IDU_o_valid), .EXU_i_ready(EXU_i_ready),
        .IDU_o_pc(IDU_o_pc), .IDU_o_valA(IDU_o_valA), .IDU_o_valB(IDU_o_valB),
        .IDU_o_valC(IDU_o_valC), .IDU_o_rd(IDU_o_rd), .IDU_o_rd_wen(IDU_o_rd_wen),
        .WBU_i_retire(WBU_i_retire), .WBU_i_rd(WBU_i_rd), .CTRL_i_flush(CTRL_i_flush),
        .IDU_o_stall_cnt(IDU_o_stall_cnt), .IDU_o_sb_err(IDU_o_sb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: a slot consumed by EXU is compared; a slot killed by flush is dropped.
    always @(negedge clk) begin
        slot_t e;
        slot_t act;
        if (rst && IDU_o_valid && (EXU_i_ready || CTRL_i_flush)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL slot_unexpected: got pc=%h with no expected entry", IDU_o_pc);
            end else begin
                e = exp_q.pop_front();
                if (EXU_i_ready) begin
                    act = '{IDU_o_pc, IDU_o_valA, IDU_o_valB, IDU_o_valC, IDU_o_rd, IDU_o_rd_wen};
                    n_cmp++;
                    if (act !== e) begin
                        n_err++;
                        $display("FAIL slot pc=%h: got a=%h b=%h c=%h rd=%0d wen=%b expected pc=%h a=%h b=%h c=%h rd=%0d wen=%b",
                                 e.pc, act.a, act.b, act.c, act.rd, act.wen,
                                 e.pc, e.a, e.b, e.c, e.rd, e.wen);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input valc_sel_e sel,
                         input logic wen, input logic u1, input logic u2);
        IFU_i_valid     = 1'b1;
        IFU_i_instr     = instr;
        IFU_i_pc        = pc;
        CTRL_i_valC_sel = sel;
        CTRL_i_reg_wen  = wen;
        CTRL_i_use_rs1  = u1;
        CTRL_i_use_rs2  = u2;
    endtask

    // Present one instruction, wait (bounded) until accepted, and queue its expected slot.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input valc_sel_e sel,
                         input logic wen, input logic u1, input logic u2,
                         input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec);
        int    waited;
        logic  fired;
        slot_t e;
        waited = 0;
        fired  = 1'b0;
        drive(instr, pc, sel, wen, u1, u2);
        while (!fired && waited < 40) begin
            @(negedge clk);
            if (IDU_o_ready) fired = 1'b1;
            else waited++;
        end
        if (fired) begin
            e.pc  = pc;
            e.a   = ea;
            e.b   = eb;
            e.c   = ec;
            e.rd  = instr[11:7];
            e.wen = wen && (instr[11:7] != 5'd0);
            exp_q.push_back(e);
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout pc=%h: got ready=0 for 40 cycles expected acceptance", pc);
        end
        tick();
        IFU_i_valid = 1'b0;
    endtask

    task automatic retire(input logic [4:0] r, input logic [31:0] val);
        WBU_i_retire = 1'b1;
        WBU_i_rd     = r;
        rf[r]        = val;
        tick();
        WBU_i_retire = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1111_0000 + i;
        rf[0] = '0;
        IFU_i_valid = 1'b0; IFU_i_instr = '0; IFU_i_pc = '0;
        CTRL_i_valC_sel = VALC_ZERO; CTRL_i_reg_wen = 1'b0;
        CTRL_i_use_rs1 = 1'b0; CTRL_i_use_rs2 = 1'b0;
        EXU_i_ready = 1'b1; WBU_i_retire = 1'b0; WBU_i_rd = '0; CTRL_i_flush = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_valid", IDU_o_valid, 0);
        check("rst_pc", IDU_o_pc, 0);
        check("rst_valC", IDU_o_valC, 0);
        check("rst_stall_cnt", IDU_o_stall_cnt, 0);
        check("rst_sb_err", IDU_o_sb_err, 0);
        rst = 1'b1;

        // 1: addi x5,x0,7
        issue(32'h0070_0293, 32'h100, VALC_I, 1, 1, 0, 32'h0, 32'h1111_0007, 32'h7);
        check("addi_valid", IDU_o_valid, 1);
        check("addi_rd", IDU_o_rd, 5);
        check("addi_valC", IDU_o_valC, 7);
        check("addi_sb5", dut.sb[5], 1);

        // 2: add x6,x5,x5 stalls on x5 until retired
        drive(32'h0052_8333, 32'h104, VALC_R, 1, 1, 1);
        tick(); tick(); tick();
        check("raw_stall_cnt", IDU_o_stall_cnt, 3);
        check("raw_ready", IDU_o_ready, 0);
        retire(5'd5, 32'hAAAA_0005);
        check("raw_retire_cnt", IDU_o_stall_cnt, 4);
        check("raw_ready_after", IDU_o_ready, 1);
        issue(32'h0052_8333, 32'h104, VALC_R, 1, 1, 1, 32'hAAAA_0005, 32'hAAAA_0005, 32'h0);

        // 3: immediate formats
        issue(32'hFE00_0EE3, 32'h108, VALC_B, 0, 1, 1, 32'h0, 32'h0, 32'hFFFF_FFFC);
        issue(32'h1234_54B7, 32'h10C, VALC_U, 1, 0, 0, 32'h1111_0008, 32'h1111_0003, 32'h1234_5000);
        issue(32'h41F1_5093, 32'h110, VALC_I_SHAMT, 0, 1, 0, 32'h1111_0002, 32'h1111_001F, 32'h1F);
        issue(32'hFE51_2C23, 32'h114, VALC_S, 0, 1, 1, 32'h1111_0002, 32'hAAAA_0005, 32'hFFFF_FFF8);
        issue(32'h8000_00EF, 32'h118, VALC_J, 0, 0, 0, 32'h0, 32'h0, 32'hFFF0_0000);
        check("imm_stall_cnt", IDU_o_stall_cnt, 4);

        // 4: flush kills a held writer of x7
        tick();
        EXU_i_ready = 1'b0;
        issue(32'h0030_0393, 32'h11C, VALC_I, 1, 0, 0, 32'h0, 32'h1111_0003, 32'h3);
        check("hold_sb7", dut.sb[7], 1);
        tick();
        check("hold_valid", IDU_o_valid, 1);
        check("hold_valC", IDU_o_valC, 3);
        check("hold_pc", IDU_o_pc, 32'h11C);
        CTRL_i_flush = 1'b1;
        drive(32'h0000_0013, 32'h120, VALC_I, 0, 0, 0);
        #1;
        check("flush_ready", IDU_o_ready, 0);
        tick();
        CTRL_i_flush = 1'b0;
        IFU_i_valid  = 1'b0;
        check("flush_valid", IDU_o_valid, 0);
        check("flush_sb7", dut.sb[7], 0);
        check("flush_stall_cnt", IDU_o_stall_cnt, 5);
        EXU_i_ready = 1'b1;

        // 5: scoreboard saturation on x8, then an unmatched retire
        for (int i = 0; i < 3; i++)
            issue(32'h0010_0413, 32'h130 + 4 * i, VALC_I, 1, 0, 0, 32'h0, 32'h1111_0001, 32'h1);
        check("sat_sb8", dut.sb[8], 3);
        drive(32'h0010_0413, 32'h13C, VALC_I, 1, 0, 0);
        tick(); tick();
        check("sat_stall_cnt", IDU_o_stall_cnt, 7);
        check("sat_ready", IDU_o_ready, 0);
        retire(5'd8, 32'hBBBB_0008);
        check("sat_retire_cnt", IDU_o_stall_cnt, 8);
        check("sat_ready_after", IDU_o_ready, 1);
        issue(32'h0010_0413, 32'h13C, VALC_I, 1, 0, 0, 32'h0, 32'h1111_0001, 32'h1);
        for (int i = 0; i < 3; i++) retire(5'd8, 32'hBBBB_0008);
        check("drain_sb8", dut.sb[8], 0);
        check("drain_sb_err", IDU_o_sb_err, 0);
        retire(5'd8, 32'hBBBB_0008);
        check("extra_retire_err", IDU_o_sb_err, 1);
        tick();
        check("sticky_err", IDU_o_sb_err, 1);

        // 6: async reset in the middle of a stall
        issue(32'h0050_0513, 32'h140, VALC_I, 1, 0, 0, 32'h0, 32'hAAAA_0005, 32'h5);
        drive(32'h0005_05B3, 32'h144, VALC_R, 1, 1, 1);
        tick(); tick();
        check("pre_rst_stall_cnt", IDU_o_stall_cnt, 10);
        #3;
        rst = 1'b0;
        #1;
        check("arst_valid", IDU_o_valid, 0);
        check("arst_stall_cnt", IDU_o_stall_cnt, 0);
        check("arst_sb_err", IDU_o_sb_err, 0);
        check("arst_pc", IDU_o_pc, 0);
        check("arst_valA", IDU_o_valA, 0);
        check("arst_sb10", dut.sb[10], 0);
        exp_q.delete();
        tick();
        rst = 1'b1;
        issue(32'h0005_05B3, 32'h144, VALC_R, 1, 1, 1, 32'h1111_000A, 32'h0, 32'h0);
        retire(5'd10, 32'hCCCC_000A);
        check("late_retire_err", IDU_o_sb_err, 1);

        // Writes to x0 are never tracked and never stall
        for (int i = 0; i < 4; i++)
            issue(32'h0010_0013, 32'h150 + 4 * i, VALC_I, 1, 1, 0, 32'h0, 32'h1111_0001, 32'h1);
        check("x0_stall_cnt", IDU_o_stall_cnt, 0);
        check("x0_sb0", dut.sb[0], 0);

        tick(); tick(); tick();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
